// File: rtl/serial_transmitter.sv
// Byte-wide serial transmitter: one-entry holding buffer in front of a shift register,
// framed as start / 8 data bits LSB first / optional even parity / stop.
module serial_transmitter #(
    parameter int unsigned CLKS_PER_BIT = 16,
    parameter int unsigned PARITY_EN    = 0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       dout,
    output logic       tx_busy,
    output logic       tx_done
);

    typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;

    localparam logic [15:0] CntMax = 16'(CLKS_PER_BIT - 1);

    state_e      state_q, state_d;
    logic [7:0]  buf_q, buf_d;
    logic        buf_full_q, buf_full_d;
    logic [7:0]  shift_q, shift_d;
    logic [15:0] cnt_q, cnt_d;
    logic [2:0]  idx_q, idx_d;
    logic        par_q, par_d;
    logic        dout_q, dout_d;
    logic        done_q, done_d;
    logic        tc;
    logic        load;

    // Next-state logic: buffer write on handshake, frame sequencing, buffer unload into shifter.
    always_comb begin
        state_d    = state_q;
        buf_d      = buf_q;
        buf_full_d = buf_full_q;
        shift_d    = shift_q;
        cnt_d      = cnt_q;
        idx_d      = idx_q;
        par_d      = par_q;
        dout_d     = dout_q;
        done_d     = 1'b0;
        load       = 1'b0;
        tc         = (cnt_q == CntMax);

        // Writes only happen while empty and unloads only while full, so they never collide.
        if (tx_valid && !buf_full_q) begin
            buf_d      = tx_data;
            buf_full_d = 1'b1;
        end

        if (state_q != StIdle) begin
            cnt_d = tc ? '0 : cnt_q + 16'd1;
        end

        unique case (state_q)
            StIdle: begin
                if (buf_full_q) load = 1'b1;
            end
            StStart: begin
                if (tc) begin
                    state_d = StData;
                    idx_d   = 3'd0;
                    dout_d  = shift_q[0];
                end
            end
            StData: begin
                if (tc) begin
                    // Parity accumulates over the bits as they leave the shifter.
                    par_d   = par_q ^ shift_q[0];
                    shift_d = shift_q >> 1;
                    if (idx_q == 3'd7) begin
                        if (PARITY_EN != 0) begin
                            state_d = StParity;
                            dout_d  = par_q ^ shift_q[0];
                        end else begin
                            state_d = StStop;
                            dout_d  = 1'b1;
                        end
                    end else begin
                        idx_d  = idx_q + 3'd1;
                        dout_d = shift_q[1];
                    end
                end
            end
            StParity: begin
                if (tc) begin
                    state_d = StStop;
                    dout_d  = 1'b1;
                end
            end
            StStop: begin
                if (tc) begin
                    done_d = 1'b1;
                    if (buf_full_q) begin
                        load = 1'b1;
                    end else begin
                        state_d = StIdle;
                        dout_d  = 1'b1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase

        // Start a frame from the buffer; from STOP this chains frames with no idle gap.
        if (load) begin
            state_d    = StStart;
            shift_d    = buf_q;
            buf_full_d = 1'b0;
            cnt_d      = '0;
            idx_d      = 3'd0;
            par_d      = 1'b0;
            dout_d     = 1'b0;
        end
    end

    // State registers; reset forces the line idle and drops any buffered byte.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            buf_q      <= '0;
            buf_full_q <= 1'b0;
            shift_q    <= '0;
            cnt_q      <= '0;
            idx_q      <= '0;
            par_q      <= 1'b0;
            dout_q     <= 1'b1;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            buf_q      <= buf_d;
            buf_full_q <= buf_full_d;
            shift_q    <= shift_d;
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            par_q      <= par_d;
            dout_q     <= dout_d;
            done_q     <= done_d;
        end
    end

    assign tx_ready = ~buf_full_q;
    assign tx_busy  = (state_q != StIdle);
    assign dout     = dout_q;
    assign tx_done  = done_q;

endmodule

// File: tb/tb_serial_transmitter.sv
// Scoreboard bench: instance 0 without parity, instance 1 with parity, both 4 clocks per bit.
module tb_serial_transmitter;

    logic       clk;
    logic       rst_n;
    logic [1:0] tx_valid;
    logic [7:0] tx_data [2];
    logic [1:0] tx_ready_w;
    logic [1:0] dout_w;
    logic [1:0] tx_busy_w;
    logic [1:0] tx_done_w;

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;
    int done_cnt [2];
    int done_last [2];
    int done_prev [2];
    logic [7:0] q0 [$];
    logic [7:0] q1 [$];

    serial_transmitter #(.CLKS_PER_BIT(4), .PARITY_EN(0)) u_dut0 (
        .clk      (clk),
        .rst_n    (rst_n),
        .tx_data  (tx_data[0]),
        .tx_valid (tx_valid[0]),
        .tx_ready (tx_ready_w[0]),
        .dout     (dout_w[0]),
        .tx_busy  (tx_busy_w[0]),
        .tx_done  (tx_done_w[0])
    );

    serial_transmitter #(.CLKS_PER_BIT(4), .PARITY_EN(1)) u_dut1 (
        .clk      (clk),
        .rst_n    (rst_n),
        .tx_data  (tx_data[1]),
        .tx_valid (tx_valid[1]),
        .tx_ready (tx_ready_w[1]),
        .dout     (dout_w[1]),
        .tx_busy  (tx_busy_w[1]),
        .tx_done  (tx_done_w[1])
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, required finish");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h required %0h", tag, got, exp);
        end
    endtask

    // tx_done pulse log, sampled on the falling edge.
    initial begin
        for (int k = 0; k < 2; k++) begin
            done_cnt[k]  = 0;
            done_last[k] = 0;
            done_prev[k] = 0;
        end
        forever begin
            @(negedge clk);
            for (int k = 0; k < 2; k++) begin
                if (tx_done_w[k]) begin
                    done_cnt[k]++;
                    done_prev[k] = done_last[k];
                    done_last[k] = cyc;
                end
            end
        end
    end

    // Line receiver: checks every sample of every bit against the expected frame.
    task automatic mon(input int k);
        logic [7:0]  b;
        logic [10:0] bits;
        int          nb;
        int          avail;
        logic        bad;
        logic        abort;
        forever begin
            @(negedge clk);
            while (rst_n && dout_w[k] == 1'b0) begin
                avail = (k == 0) ? q0.size() : q1.size();
                check_eq($sformatf("frame_expected%0d", k), 32'(avail != 0), 1);
                b = 8'h00;
                if (avail != 0) b = (k == 0) ? q0.pop_front() : q1.pop_front();
                nb      = (k == 1) ? 11 : 10;
                bits    = '1;
                bits[0] = 1'b0;
                bits[8:1] = b;
                if (k == 1) bits[9] = ^b;
                abort = 1'b0;
                for (int i = 0; i < nb; i++) begin
                    bad = 1'b0;
                    for (int j = 0; j < 4; j++) begin
                        if (i != 0 || j != 0) @(negedge clk);
                        if (!rst_n) begin
                            abort = 1'b1;
                            break;
                        end
                        if (dout_w[k] !== bits[i]) bad = 1'b1;
                    end
                    if (abort) break;
                    check_eq($sformatf("inst%0d_byte%0h_bit%0d", k, b, i),
                             32'(bad ? ~bits[i] : bits[i]), 32'(bits[i]));
                end
                if (abort) break;
                @(negedge clk);
                check_eq($sformatf("done_after_stop%0d", k), 32'(tx_done_w[k]), 1);
            end
        end
    endtask

    initial mon(0);
    initial mon(1);

    // Handshake one byte; returns #1 after the handshake edge.
    task automatic send(input int k, input logic [7:0] b);
        int t = 0;
        while (!tx_ready_w[k] && t < 200) begin
            @(posedge clk);
            #1;
            t++;
        end
        check_eq("ready_wait", 32'(tx_ready_w[k]), 1);
        tx_valid[k] = 1'b1;
        tx_data[k]  = b;
        @(posedge clk);
        if (k == 0) q0.push_back(b);
        else q1.push_back(b);
        #1;
        tx_valid[k] = 1'b0;
        tx_data[k]  = 8'($urandom);
    endtask

    task automatic wait_done(input int k, input int target);
        int t = 0;
        while (done_cnt[k] < target && t < 500) begin
            @(negedge clk);
            t++;
        end
        check_eq("done_wait", 32'(done_cnt[k] >= target), 1);
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    int d0;
    int d1;
    int bad_cnt;

    initial begin
        rst_n      = 1'b0;
        tx_valid   = '0;
        tx_data[0] = 8'h00;
        tx_data[1] = 8'h00;
        cycles(3);
        for (int k = 0; k < 2; k++) begin
            check_eq("rst_dout", 32'(dout_w[k]), 1);
            check_eq("rst_busy", 32'(tx_busy_w[k]), 0);
            check_eq("rst_done", 32'(tx_done_w[k]), 0);
            check_eq("rst_ready", 32'(tx_ready_w[k]), 1);
        end
        @(negedge clk);
        rst_n = 1'b1;
        cycles(2);

        // Single byte with handshake-to-start latency.
        d0 = done_cnt[0];
        send(0, 8'hA5);
        check_eq("hs_ready_low", 32'(tx_ready_w[0]), 0);
        check_eq("hs_dout_idle", 32'(dout_w[0]), 1);
        check_eq("hs_busy_idle", 32'(tx_busy_w[0]), 0);
        cycles(1);
        check_eq("start_ready", 32'(tx_ready_w[0]), 1);
        check_eq("start_dout", 32'(dout_w[0]), 0);
        check_eq("start_busy", 32'(tx_busy_w[0]), 1);
        wait_done(0, d0 + 1);
        repeat (2) @(negedge clk);
        check_eq("single_dout_idle", 32'(dout_w[0]), 1);
        check_eq("single_busy_low", 32'(tx_busy_w[0]), 0);
        check_eq("single_done_cnt", 32'(done_cnt[0] - d0), 1);

        // Back-to-back: second byte accepted while first is in DATA.
        d0 = done_cnt[0];
        send(0, 8'h3C);
        cycles(8);
        check_eq("b2b_busy", 32'(tx_busy_w[0]), 1);
        send(0, 8'hC3);
        wait_done(0, d0 + 2);
        check_eq("b2b_done_spacing", 32'(done_last[0] - done_prev[0]), 40);
        cycles(2);

        // Backpressure: a valid while the buffer is full must be ignored.
        d0 = done_cnt[0];
        send(0, 8'h11);
        cycles(6);
        send(0, 8'h96);
        check_eq("bp_ready_low", 32'(tx_ready_w[0]), 0);
        tx_valid[0] = 1'b1;
        tx_data[0]  = 8'hFF;
        cycles(1);
        tx_valid[0] = 1'b0;
        check_eq("bp_ready_still_low", 32'(tx_ready_w[0]), 0);
        wait_done(0, d0 + 2);
        cycles(60);
        check_eq("bp_frames", 32'(done_cnt[0] - d0), 2);
        check_eq("bp_queue_empty", 32'(q0.size()), 0);

        // Parity instance: 0x07 -> parity 1, 0x03 -> parity 0, 11-bit frames.
        d1 = done_cnt[1];
        send(1, 8'h07);
        send(1, 8'h03);
        wait_done(1, d1 + 2);
        check_eq("par_done_spacing", 32'(done_last[1] - done_prev[1]), 44);
        cycles(2);

        // Loopback set.
        d0 = done_cnt[0];
        send(0, 8'h00);
        send(0, 8'hFF);
        send(0, 8'h5A);
        wait_done(0, d0 + 3);
        cycles(2);
        check_eq("lb_frames", 32'(done_cnt[0] - d0), 3);
        check_eq("lb_queue_empty", 32'(q0.size()), 0);

        // Reset in DATA bit 3 with a second byte buffered; both are dropped.
        send(0, 8'hF0);
        cycles(3);
        send(0, 8'h0F);
        cycles(14);
        check_eq("mid_busy", 32'(tx_busy_w[0]), 1);
        check_eq("mid_ready_low", 32'(tx_ready_w[0]), 0);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("arst_dout", 32'(dout_w[0]), 1);
        check_eq("arst_ready", 32'(tx_ready_w[0]), 1);
        check_eq("arst_busy", 32'(tx_busy_w[0]), 0);
        check_eq("arst_done", 32'(tx_done_w[0]), 0);
        repeat (2) @(negedge clk);
        q0.delete();
        d0 = done_cnt[0];
        rst_n = 1'b1;
        bad_cnt = 0;
        repeat (50) begin
            @(negedge clk);
            if (dout_w[0] !== 1'b1 || tx_busy_w[0] !== 1'b0) bad_cnt++;
        end
        check_eq("post_rst_idle", 32'(bad_cnt), 0);
        check_eq("post_rst_no_done", 32'(done_cnt[0] - d0), 0);
        check_eq("post_rst_ready", 32'(tx_ready_w[0]), 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/serial_transmitter.md
SERIAL_TRANSMITTER -- requirements
Module: serial_transmitter

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 16, giving clk cycles per serial bit; legal range 2..65535.
REQ-002 SHALL have parameter PARITY_EN, default 0, where 1 inserts an even-parity bit after data bit 7.
REQ-003 SHALL have port clk  input  1  system clock; all state changes on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port tx_data  input  8  byte to send, captured on handshake.
REQ-006 SHALL have port tx_valid  input  1  producer offers tx_data this cycle.
REQ-007 SHALL have port tx_ready  output  1  holding buffer empty; handshake when tx_valid && tx_ready at a rising edge.
REQ-008 SHALL have port dout  output  1  serial line, idle high, registered, glitch-free.
REQ-009 SHALL have port tx_busy  output  1  high in any state other than IDLE.
REQ-010 SHALL have port tx_done  output  1  single-cycle pulse per completed frame.

Function
REQ-011 SHALL use frame format: start bit 0, data bits 0..7 LSB first, parity bit if PARITY_EN, stop bit 1; each bit lasts exactly CLKS_PER_BIT clk cycles.
REQ-012 SHALL contain a one-entry holding buffer (8-bit data plus full flag) and a separate 8-bit shift register.
REQ-013 SHALL drive tx_ready = NOT buffer-full, from a register; tx_valid while tx_ready=0 SHALL be ignored with no side effect.
REQ-014 SHALL implement FSM states IDLE, START, DATA, PARITY, STOP; PARITY SHALL be skipped when PARITY_EN=0.
REQ-015 SHALL transition IDLE->START on the first edge at which the buffer is full; on that edge, shift register loads the buffer, buffer clears, dout goes 0.
REQ-016 SHALL, for a handshake at edge N in IDLE, have the buffer full after N, dout=0 after edge N+1, and tx_ready=1 again after edge N+1.
REQ-017 SHALL use a bit-cycle counter 0..CLKS_PER_BIT-1 with terminal-count advance; START->DATA, DATA repeats 8 times via 3-bit index, then ->PARITY or ->STOP, PARITY->STOP.
REQ-018 SHALL compute parity as XOR of the 8 shifted bits, even parity (dout = ^byte).
REQ-019 SHALL, at the terminal count of STOP, go to START (loading the buffer, no idle gap) if the buffer is full, else to IDLE with dout=1.
REQ-020 SHALL assert tx_done for exactly the cycle after the STOP terminal-count edge, including back-to-back frames.
REQ-021 SHALL allow a new handshake during any state of an ongoing frame whenever tx_ready=1; byte is sent as the next frame.
REQ-022 SHALL NOT allow buffer write and buffer unload on the same edge, since tx_ready is 0 whenever the buffer is full.
REQ-023 SHALL NOT require tx_data to stay stable after the handshake edge.

Reset
REQ-024 SHALL, on rst_n low, immediately force dout=1, tx_busy=0, tx_done=0, tx_ready=1, state IDLE, buffer empty, counters and shift register 0.
REQ-025 SHALL, on reset mid-frame, abandon the frame and discard the buffered byte; after release, no transmission starts until a new handshake.
REQ-026 SHALL deassert reset asynchronously-safe, with the first state change on the first rising clk edge after rst_n goes high.

Verification (CLKS_PER_BIT=4, PARITY_EN=0 unless stated)
REQ-027 SHALL verify a single byte: send 0xA5 -> dout reads 0,1,0,1,0,0,1,0,1,1, each bit held 4 cycles, tx_done pulse once, then dout=1 and tx_busy=0.
REQ-028 SHALL verify back-to-back frames: send 0x3C, then 0xC3 while the first is in DATA -> 20 bit periods, no idle gap between frames, two tx_done pulses 40 cycles apart.
REQ-029 SHALL verify backpressure: with buffer full, pulse tx_valid with 0xFF -> tx_ready=0, byte ignored, only the buffered byte is sent.
REQ-030 SHALL verify parity: with PARITY_EN=1, send 0x07 -> parity bit 1; send 0x03 -> parity bit 0; frame is 11 bits.
REQ-031 SHALL verify reset mid-frame: assert rst_n low during DATA bit 3 -> dout=1 with no clock edge required, tx_ready=1; after release, dout stays 1 for 50 cycles.
REQ-032 SHALL verify loopback: dout driven into the team's serial receiver with matching rate -> received bytes 0x00, 0xFF, 0x5A are equal to sent, one status pulse each.
